// File: rtl/regfile_writeback_mp.sv
// Multi-channel register write-back stage: captures up to NWB retiring results in a
// staging register, commits them to the register file one cycle later, and bypasses
// the staged values onto the combinational read ports.
module regfile_writeback_mp #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NREGS    = 16,
  parameter int unsigned NWB      = 2,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b0,
  parameter int unsigned CNTW     = 32,
  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic                stage_busy,
  output logic                wb_conflict,
  output logic [CNTW-1:0]     commit_count
);

  // One extra bit so NREGS itself is representable for the range check.
  localparam logic [AW:0] NregsW = (AW+1)'(NREGS);

  logic [NWB-1:0]      stg_valid_q, stg_valid_d;
  logic [NWB*AW-1:0]   stg_addr_q, stg_addr_d;
  logic [NWB*XLEN-1:0] stg_data_q, stg_data_d;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic                conflict_q, conflict_d;
  logic [CNTW-1:0]     count_q, count_d;

  logic [NWB-1:0]      wr_en;
  logic                conflict_now;
  logic                dup;
  logic [CNTW-1:0]     n_writes;
  logic [AW-1:0]       ra;
  logic [XLEN-1:0]     rval;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NregsW;
  endfunction

  // A staged channel actually writes only if valid, in range and not the zero register.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < NWB; i++) begin
      wr_en[i] = stg_valid_q[i] && in_range(stg_addr_q[i*AW +: AW]) &&
                 !(ZERO_REG && (stg_addr_q[i*AW +: AW] == '0));
    end
  end

  // Commit staged writes (highest channel wins), count distinct addresses, flag collisions.
  always_comb begin
    regs_d       = regs_q;
    conflict_now = 1'b0;
    n_writes     = '0;
    dup          = 1'b0;
    for (int unsigned i = 0; i < NWB; i++) begin
      if (wr_en[i]) begin
        regs_d[stg_addr_q[i*AW +: AW]] = stg_data_q[i*XLEN +: XLEN];
        dup = 1'b0;
        for (int unsigned j = i + 1; j < NWB; j++) begin
          if (wr_en[j] && (stg_addr_q[j*AW +: AW] == stg_addr_q[i*AW +: AW])) dup = 1'b1;
        end
        // Only the last writer of an address is counted.
        if (dup) conflict_now = 1'b1;
        else     n_writes = n_writes + CNTW'(1);
      end
    end
    if (stall) regs_d = regs_q;
  end

  // Next state for staging, counter and conflict pulse; everything holds under stall.
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    conflict_d  = conflict_q;
    count_d     = count_q;
    if (!stall) begin
      stg_valid_d = wb_valid;
      stg_addr_d  = wb_addr;
      stg_data_d  = wb_data;
      conflict_d  = conflict_now;
      count_d     = count_q + n_writes;
    end
  end

  // State registers with synchronous active-low reset taking priority over stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_valid_q <= '0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      conflict_q  <= 1'b0;
      count_q     <= '0;
      for (int unsigned k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      conflict_q  <= conflict_d;
      count_q     <= count_d;
      for (int unsigned k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Read ports: zero register, then youngest staged match, then register file.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rval    = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      ra   = rd_addr[p*AW +: AW];
      rval = in_range(ra) ? regs_q[ra] : '0;
      for (int unsigned i = 0; i < NWB; i++) begin
        if (stg_valid_q[i] && (stg_addr_q[i*AW +: AW] == ra) && in_range(ra)) begin
          rval = stg_data_q[i*XLEN +: XLEN];
        end
      end
      if (ZERO_REG && (ra == '0)) rval = '0;
      rd_data[p*XLEN +: XLEN] = rval;
    end
  end

  assign stage_busy   = |stg_valid_q;
  assign wb_conflict  = conflict_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_regfile_writeback_mp.sv
// Bench for regfile_writeback_mp: three instances (default, zero register, 4-bit counter)
// share one stimulus stream; read expectations go through a scoreboard queue.
module tb_regfile_writeback_mp;

  localparam int XLEN = 64;
  localparam int AW   = 4;

  logic         clk = 1'b0;
  logic         rst_n, stall;
  logic [1:0]   wb_valid;
  logic [7:0]   wb_addr;
  logic [127:0] wb_data;
  logic [7:0]   rd_addr;
  logic [127:0] rd_m, rd_z, rd_c;
  logic         busy_m, busy_z, busy_c;
  logic         conf_m, conf_z, conf_c;
  logic [31:0]  cnt_m, cnt_z;
  logic [3:0]   cnt_c;

  always #5 clk = ~clk;

  regfile_writeback_mp dut_m (
    .clk(clk), .rst_n(rst_n), .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .rd_addr(rd_addr), .rd_data(rd_m), .stage_busy(busy_m),
    .wb_conflict(conf_m), .commit_count(cnt_m)
  );

  regfile_writeback_mp #(.ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .rd_addr(rd_addr), .rd_data(rd_z), .stage_busy(busy_z),
    .wb_conflict(conf_z), .commit_count(cnt_z)
  );

  regfile_writeback_mp #(.CNTW(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .stall(stall), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .rd_addr(rd_addr), .rd_data(rd_c), .stage_busy(busy_c),
    .wb_conflict(conf_c), .commit_count(cnt_c)
  );

  typedef struct {
    string       name;
    int          which;
    int          port;
    logic [3:0]  addr;
    logic [63:0] exp;
  } rd_exp_t;

  rd_exp_t     sb_q[$];
  rd_exp_t     e;
  logic [63:0] obs;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [63:0] d0,
                       input logic [3:0] a1, input logic [63:0] d1);
    wb_valid = v;
    wb_addr  = {a1, a0};
    wb_data  = {d1, d0};
  endtask

  task automatic push(input string n, input int w, input int p, input logic [3:0] a,
                      input logic [63:0] x);
    rd_exp_t t;
    t.name = n; t.which = w; t.port = p; t.addr = a; t.exp = x;
    sb_q.push_back(t);
  endtask

  task automatic rd(input int w, input int p, input logic [3:0] a, output logic [63:0] d);
    rd_addr[p*AW +: AW] = a;
    #1;
    case (w)
      0:       d = rd_m[p*XLEN +: XLEN];
      1:       d = rd_z[p*XLEN +: XLEN];
      default: d = rd_c[p*XLEN +: XLEN];
    endcase
  endtask

  task automatic test_reset();
    drive(2'b11, 4'd1, 64'h11, 4'd2, 64'h22);
    tick();
    drive(2'b01, 4'd4, 64'h44, 4'd0, 64'h0);
    tick();
    push("fill_a1", 0, 0, 4'd1, 64'h11);
    push("fill_a4_bypass", 0, 1, 4'd4, 64'h44);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    rst_n = 1'b0; stall = 1'b1; drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    tick();
    rst_n = 1'b1; stall = 1'b0;
    push("rst_a1", 0, 0, 4'd1, 64'h0);
    push("rst_a2", 0, 1, 4'd2, 64'h0);
    push("rst_a4", 0, 0, 4'd4, 64'h0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (cnt_m !== 32'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", cnt_m); end
    n_cmp++;
    if (busy_m !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy_m); end
    n_cmp++;
    if (conf_m !== 1'b0) begin n_bad++; $display("FAIL rst_conflict: got %b expected 0", conf_m); end
    tick();
    push("rst_a4_discarded", 0, 0, 4'd4, 64'h0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_single();
    drive(2'b01, 4'd3, 64'h0123_4567_89AB_CDEF, 4'd0, 64'h0);
    push("single_bypass", 0, 0, 4'd3, 64'h0123_4567_89AB_CDEF);
    tick();
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (busy_m !== 1'b1) begin n_bad++; $display("FAIL single_busy1: got %b expected 1", busy_m); end
    n_cmp++;
    if (cnt_m !== 32'd0) begin n_bad++; $display("FAIL single_count0: got %0d expected 0", cnt_m); end
    push("single_rf", 0, 1, 4'd3, 64'h0123_4567_89AB_CDEF);
    tick();
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (cnt_m !== 32'd1) begin n_bad++; $display("FAIL single_count1: got %0d expected 1", cnt_m); end
    n_cmp++;
    if (busy_m !== 1'b0) begin n_bad++; $display("FAIL single_busy0: got %b expected 0", busy_m); end
  endtask

  task automatic test_collision();
    drive(2'b11, 4'd5, 64'hAAAA, 4'd5, 64'h5555);
    push("coll_bypass", 0, 1, 4'd5, 64'h5555);
    tick();
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (conf_m !== 1'b0) begin n_bad++; $display("FAIL coll_conf_early: got %b expected 0", conf_m); end
    push("coll_rf", 0, 0, 4'd5, 64'h5555);
    tick();
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (conf_m !== 1'b1) begin n_bad++; $display("FAIL coll_conf_pulse: got %b expected 1", conf_m); end
    n_cmp++;
    if (cnt_m !== 32'd2) begin n_bad++; $display("FAIL coll_count: got %0d expected 2", cnt_m); end
    tick();
    n_cmp++;
    if (conf_m !== 1'b0) begin n_bad++; $display("FAIL coll_conf_clear: got %b expected 0", conf_m); end
  endtask

  task automatic test_stall();
    drive(2'b10, 4'd0, 64'h0, 4'd7, 64'h77);
    tick();
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(2'b01, 4'd8, 64'h88 + 64'(c), 4'd0, 64'h0);
      tick();
      push("stall_a7_bypass", 0, 0, 4'd7, 64'h77);
      push("stall_a8_not_captured", 0, 1, 4'd8, 64'h0);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
        if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
      end
      n_cmp++;
      if (cnt_m !== 32'd2) begin n_bad++; $display("FAIL stall_count_hold: got %0d expected 2", cnt_m); end
      n_cmp++;
      if (busy_m !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b expected 1", busy_m); end
    end
    stall = 1'b0;
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    tick();
    push("stall_a7_rf", 0, 0, 4'd7, 64'h77);
    push("stall_a8_rf", 0, 1, 4'd8, 64'h0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (cnt_m !== 32'd3) begin n_bad++; $display("FAIL stall_commit_once: got %0d expected 3", cnt_m); end
    tick();
    n_cmp++;
    if (cnt_m !== 32'd3) begin n_bad++; $display("FAIL stall_no_double: got %0d expected 3", cnt_m); end
  endtask

  task automatic test_zero_reg();
    drive(2'b11, 4'd0, 64'hFF, 4'd2, 64'h22);
    tick();
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    push("zero_a0_no_bypass", 1, 0, 4'd0, 64'h0);
    push("zero_a2_bypass", 1, 1, 4'd2, 64'h22);
    push("nozero_a0_bypass", 0, 0, 4'd0, 64'hFF);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    tick();
    push("zero_a0_rf", 1, 0, 4'd0, 64'h0);
    push("zero_a2_rf", 1, 1, 4'd2, 64'h22);
    push("nozero_a0_rf", 0, 0, 4'd0, 64'hFF);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
    n_cmp++;
    if (cnt_z !== 32'd4) begin n_bad++; $display("FAIL zero_count: got %0d expected 4", cnt_z); end
    n_cmp++;
    if (conf_z !== 1'b0) begin n_bad++; $display("FAIL zero_conf: got %b expected 0", conf_z); end
    n_cmp++;
    if (cnt_m !== 32'd5) begin n_bad++; $display("FAIL nozero_count: got %0d expected 5", cnt_m); end
    // Collision on address 0: only the non-zero-register instance flags it.
    drive(2'b11, 4'd0, 64'h1, 4'd0, 64'h2);
    tick();
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    tick();
    n_cmp++;
    if (conf_z !== 1'b0) begin n_bad++; $display("FAIL zero_coll_conf: got %b expected 0", conf_z); end
    n_cmp++;
    if (cnt_z !== 32'd4) begin n_bad++; $display("FAIL zero_coll_count: got %0d expected 4", cnt_z); end
    n_cmp++;
    if (conf_m !== 1'b1) begin n_bad++; $display("FAIL nozero_coll_conf: got %b expected 1", conf_m); end
    n_cmp++;
    if (cnt_m !== 32'd6) begin n_bad++; $display("FAIL nozero_coll_count: got %0d expected 6", cnt_m); end
    push("nozero_coll_a0", 0, 1, 4'd0, 64'h2);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  task automatic test_back_to_back_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0) drive(2'b01, 4'(i % 16), 64'h1000 + 64'(i), 4'd0, 64'h0);
      else            drive(2'b10, 4'd0, 64'h0, 4'(i % 16), 64'h1000 + 64'(i));
      tick();
    end
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    tick();
    n_cmp++;
    if (cnt_c !== 4'd1) begin n_bad++; $display("FAIL wrap_count4: got %0d expected 1", cnt_c); end
    n_cmp++;
    if (cnt_m !== 32'd17) begin n_bad++; $display("FAIL wrap_count32: got %0d expected 17", cnt_m); end
    push("b2b_a0", 0, 0, 4'd0, 64'h1010);
    push("b2b_a15", 0, 1, 4'd15, 64'h100F);
    push("b2b_a6", 2, 0, 4'd6, 64'h1006);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); rd(e.which, e.port, e.addr, obs); n_cmp++;
      if (obs !== e.exp) begin n_bad++; $display("FAIL %s: got %h expected %h", e.name, obs, e.exp); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    rd_addr = '0;
    drive(2'b00, 4'd0, 64'h0, 4'd0, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_collision();
    test_stall();
    test_zero_reg();
    test_back_to_back_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
